// File: rtl/miner_axil_pkg.sv
// miner_axil_pkg: register map, STATUS bit positions and AXI response codes for miner_axil_regfile
package miner_axil_pkg;
  localparam int REG_CTRL      = 0;
  localparam int REG_STATUS    = 1;
  localparam int REG_NONCE     = 2;
  localparam int REG_FOUND_CNT = 3;
  localparam int REG_HDR_BASE  = 4;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int ST_BUSY   = 0;
  localparam int ST_FOUND  = 1;
  localparam int ST_IRQ_EN = 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction
endpackage

// File: rtl/miner_axil_wstrb_merge.sv
// miner_axil_wstrb_merge: byte-lane merge of old and new word, limited to the register's RW bits
module miner_axil_wstrb_merge
  import miner_axil_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [31:0] rw_mask_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] data_o
);
  logic [31:0] en;
  assign en     = strb_mask(strb_i) & rw_mask_i;
  assign data_o = (old_i & ~en) | (new_i & en);
endmodule

// File: rtl/miner_axil_regfile.sv
// miner_axil_regfile: AXI4-Lite register file for the miner core; MINER_AXIL_IRQ_EN adds the irq output and STATUS.IRQ_EN
module miner_axil_regfile
  import miner_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS           = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            ctrl_start,
  output logic                            ctrl_abort,
  output logic [32*(NUM_REGS-4)-1:0]      hdr_words,
  input  logic                            core_busy,
  input  logic                            core_found,
`ifdef MINER_AXIL_IRQ_EN
  output logic                            irq,
`endif
  input  logic [31:0]                     core_nonce
);
  localparam int IW    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NH    = NUM_REGS - REG_HDR_BASE;
  localparam int DEPTH = 2**IW;
`ifdef MINER_AXIL_IRQ_EN
  localparam logic [31:0] ST_RW_MASK = 32'h1 << ST_IRQ_EN;
`else
  localparam logic [31:0] ST_RW_MASK = 32'h0;
`endif
  logic rdy_q, aw_full_q, w_full_q, b_valid_q, r_valid_q;
  logic [IW-1:0] aw_idx_q;
  logic [31:0] w_data_q, r_data_q, nonce_q, cnt_q;
  logic [3:0] w_strb_q;
  logic [1:0] b_resp_q, r_resp_q;
  logic start_q, abort_q, found_q, found_d, irq_en;
  logic [32*NH-1:0] hdr_q, hdr_d;
  logic aw_hs, w_hs, ar_hs, commit, wr_ok, wr_en, rd_ok, st_wr, ctrl_wr;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [31:0] wr_data, merged;
  logic [3:0] wr_strb;
  logic [31:0] reg_rd [DEPTH];
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_AWREADY = rdy_q & ~aw_full_q;
  assign S_AXI_WREADY  = rdy_q & ~w_full_q;
  assign S_AXI_ARREADY = rdy_q & ~r_valid_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = b_resp_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = r_resp_q;
  assign ctrl_start    = start_q;
  assign ctrl_abort    = abort_q;
  assign hdr_words     = hdr_q;
  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  // The write commits on the edge that fills the second holder, so BVALID is visible the next cycle
  assign wr_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;
  assign commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~b_valid_q;
  assign wr_ok   = 32'(wr_idx) < NUM_REGS;
  assign wr_en   = commit & wr_ok;
  assign st_wr   = wr_en & (wr_idx == IW'(REG_STATUS));
  assign ctrl_wr = wr_en & (wr_idx == IW'(REG_CTRL));
  assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_ok   = 32'(rd_idx) < NUM_REGS;
  // A new core_found beats a same-cycle W1C so no find is ever lost
  assign found_d = core_found | (found_q & ~(st_wr & wr_data[ST_FOUND]));
  // Read view of every decodable index; unimplemented indices read as zero
  always_comb begin
    for (int i = 0; i < DEPTH; i++) reg_rd[i] = '0;
    reg_rd[REG_STATUS]    = {29'b0, irq_en, found_q, core_busy};
    reg_rd[REG_NONCE]     = nonce_q;
    reg_rd[REG_FOUND_CNT] = cnt_q;
    for (int i = 0; i < NH; i++) reg_rd[i+REG_HDR_BASE] = hdr_q[i*32 +: 32];
  end
  miner_axil_wstrb_merge u_merge (
    .old_i     (reg_rd[wr_idx]),
    .new_i     (wr_data),
    .rw_mask_i ((wr_idx == IW'(REG_STATUS)) ? ST_RW_MASK : 32'hFFFF_FFFF),
    .strb_i    (wr_strb),
    .data_o    (merged)
  );
  // Header word next-state: only the addressed word takes the merged value
  always_comb begin
    hdr_d = hdr_q;
    for (int i = 0; i < NH; i++) hdr_d[i*32 +: 32] = (wr_en && wr_idx == IW'(i + REG_HDR_BASE)) ? merged : hdr_q[i*32 +: 32];
  end
  // Write channel: AW/W holders stay full until the B handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_q     <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      rdy_q     <= 1'b1;
      aw_full_q <= (b_valid_q & S_AXI_BREADY) ? 1'b0 : aw_full_q | aw_hs;
      w_full_q  <= (b_valid_q & S_AXI_BREADY) ? 1'b0 : w_full_q | w_hs;
      aw_idx_q  <= aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
      w_data_q  <= w_hs ? S_AXI_WDATA : w_data_q;
      w_strb_q  <= w_hs ? S_AXI_WSTRB : w_strb_q;
      b_valid_q <= commit | (b_valid_q & ~S_AXI_BREADY);
      b_resp_q  <= commit ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : b_resp_q;
    end
  end
  // Read channel: data captured at the AR handshake, held until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_valid_q <= ar_hs | (r_valid_q & ~S_AXI_RREADY);
      r_data_q  <= ar_hs ? (rd_ok ? reg_rd[rd_idx] : 32'h0) : r_data_q;
      r_resp_q  <= ar_hs ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : r_resp_q;
    end
  end
  // Register state: control pulses, found/nonce capture, counter and header words
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      found_q <= 1'b0;
      nonce_q <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
    end else begin
      start_q <= ctrl_wr & wr_data[CTRL_START];
      abort_q <= ctrl_wr & wr_data[CTRL_ABORT];
      found_q <= found_d;
      nonce_q <= core_found ? core_nonce : nonce_q;
      cnt_q   <= cnt_q + 32'(core_found);
      hdr_q   <= hdr_d;
    end
  end
`ifdef MINER_AXIL_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq_en = irq_en_q;
  assign irq    = irq_q;
  // Interrupt enable and registered level interrupt
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= st_wr ? merged[ST_IRQ_EN] : irq_en_q;
      irq_q    <= found_q & irq_en_q;
    end
  end
`else
  assign irq_en = 1'b0;
`endif
endmodule
